spec_tag_tracker: RTL and testbench

- Upstream neighbour of the speculation label-propagation stage.
- Allocates 4-bit speculation tags to in-flight speculative operations, tracks them in age order and accepts out-of-order resolutions (correct/mispredicted).
- Drives the one-cycle misspeculation notification (`l_valid`/`l_status`) that the downstream stage compares against its stored data tags.
- Retires correctly-resolved tags in order and flushes younger tags on a mispredict.

---
 rtl/spec_pkg.sv | 24 ++
 rtl/spec_tag_ring.sv | 65 ++++++
 rtl/spec_tag_tracker.sv | 123 ++++++++++++
 tb/tb_spec_tag_tracker.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spec_pkg.sv
// Shared types for the speculation tag tracker: tag type, FSM states, ring entry
// layout and modular tag arithmetic.
package spec_pkg;

  localparam int TAG_W = 4;

  typedef logic [TAG_W-1:0] spec_tag_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } spec_state_e;

  typedef struct packed {
    spec_tag_t tag;
    logic      resolved;
  } spec_entry_t;

  // Distance from b forward to a, wrapping modulo 2^TAG_W.
  function automatic spec_tag_t tag_offset(input spec_tag_t a, input spec_tag_t b);
    return a - b;
  endfunction

endpackage

// File: rtl/spec_tag_ring.sv
// Age-ordered circular buffer of speculation entries with push, pop and
// truncate-to-index (drops an entry and everything younger than it).
module spec_tag_ring
  import spec_pkg::*;
#(
  parameter int  DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  spec_tag_t        push_tag,
  input  logic             pop,
  input  logic             truncate,
  input  logic [PTR_W-1:0] trunc_idx,
  input  logic [CNT_W-1:0] trunc_len,
  input  logic             set_resolved,
  input  logic [PTR_W-1:0] lookup_idx,
  output logic             rd_resolved,
  output spec_entry_t      head_entry,
  output logic [PTR_W-1:0] head,
  output logic [CNT_W-1:0] count
);

  spec_entry_t      entry_reg  [DEPTH];
  spec_entry_t      entry_next [DEPTH];
  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [CNT_W-1:0] count_reg, count_next;

  // Push only targets the free slot at tail and resolve only targets a live
  // entry, so the two never collide on the same index.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign entry_next[gi] =
        (push && tail_reg == PTR_W'(gi))             ? spec_entry_t'{tag: push_tag, resolved: 1'b0} :
        (set_resolved && lookup_idx == PTR_W'(gi))   ? spec_entry_t'{tag: entry_reg[gi].tag, resolved: 1'b1} :
                                                       entry_reg[gi];
    end
  endgenerate

  assign count_next = truncate ? trunc_len - CNT_W'(pop)
                               : count_reg + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entry_reg[i] <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      entry_reg <= entry_next;
      if (pop) head_reg <= head_reg + PTR_W'(1);
      if (truncate)  tail_reg <= trunc_idx;
      else if (push) tail_reg <= tail_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

  assign rd_resolved = entry_reg[lookup_idx].resolved;
  assign head_entry  = entry_reg[head_reg];
  assign head        = head_reg;
  assign count       = count_reg;

endmodule

// File: rtl/spec_tag_tracker.sv
// Allocates speculation tags, tracks them in age order, accepts out-of-order
// resolutions, retires in order and flushes younger tags on a mispredict.
module spec_tag_tracker #(
  parameter int  DEPTH = 8,
  parameter int  TAG_W = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_req,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [TAG_W-1:0] res_tag,
  input  logic             res_mispred,
  output logic             l_valid,
  output logic [TAG_W-1:0] l_status,
  output logic             retire_valid,
  output logic [TAG_W-1:0] retire_tag,
  output logic             res_err,
  output logic [CNT_W-1:0] count
);

  import spec_pkg::*;

  spec_state_e      state_reg, state_next;
  logic [TAG_W-1:0] next_tag_reg;
  logic             l_valid_reg, retire_valid_reg, res_err_reg;
  logic [TAG_W-1:0] l_status_reg, retire_tag_reg;

  spec_entry_t      head_entry;
  logic [PTR_W-1:0] head_ptr, res_idx;
  logic [CNT_W-1:0] ring_count, trunc_len;
  logic [TAG_W-1:0] head_tag, res_off;
  logic             lookup_resolved, res_fire, in_range, res_ok;
  logic             mispred, correct, retire, alloc_fire;

  // Outstanding tags are contiguous and end at next_tag-1, so the head tag and
  // any tag's ring slot follow from modular arithmetic alone.
  assign head_tag  = next_tag_reg - TAG_W'(ring_count);
  assign res_off   = tag_offset(res_tag, head_tag);
  assign in_range  = res_off < TAG_W'(ring_count);
  assign res_idx   = head_ptr + PTR_W'(res_off);
  assign trunc_len = CNT_W'(res_off);

  assign res_fire   = res_valid && res_ready;
  assign res_ok     = res_fire && in_range && !lookup_resolved;
  assign mispred    = res_ok && res_mispred;
  assign correct    = res_ok && !res_mispred;
  assign retire     = (ring_count != '0) && head_entry.resolved && !(mispred && res_off == '0);
  assign alloc_fire = alloc_req && alloc_ready;

  spec_tag_ring #(.DEPTH(DEPTH)) u_ring (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (alloc_fire),
    .push_tag     (next_tag_reg),
    .pop          (retire),
    .truncate     (mispred),
    .trunc_idx    (res_idx),
    .trunc_len    (trunc_len),
    .set_resolved (correct),
    .lookup_idx   (res_idx),
    .rd_resolved  (lookup_resolved),
    .head_entry   (head_entry),
    .head         (head_ptr),
    .count        (ring_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= RUN;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (mispred) state_next = FLUSH;
      FLUSH:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Handshake readies are held low while reset is asserted.
  always_comb begin
    res_ready   = 1'b0;
    alloc_ready = 1'b0;
    if (rst_n && state_reg == RUN) begin
      res_ready   = 1'b1;
      alloc_ready = (ring_count < CNT_W'(DEPTH)) && !(res_valid && res_mispred);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      next_tag_reg     <= '0;
      l_valid_reg      <= 1'b0;
      l_status_reg     <= '0;
      retire_valid_reg <= 1'b0;
      retire_tag_reg   <= '0;
      res_err_reg      <= 1'b0;
    end else begin
      if (mispred)         next_tag_reg <= res_tag;
      else if (alloc_fire) next_tag_reg <= next_tag_reg + TAG_W'(1);
      l_valid_reg      <= mispred;
      l_status_reg     <= mispred ? res_tag : '0;
      retire_valid_reg <= retire;
      retire_tag_reg   <= retire ? head_entry.tag : '0;
      res_err_reg      <= res_fire && !res_ok;
    end
  end

  assign alloc_tag    = next_tag_reg;
  assign l_valid      = l_valid_reg;
  assign l_status     = l_status_reg;
  assign retire_valid = retire_valid_reg;
  assign retire_tag   = retire_tag_reg;
  assign res_err      = res_err_reg;
  assign count        = ring_count;

endmodule

// File: tb/tb_spec_tag_tracker.sv
// Bench for spec_tag_tracker: directed scenarios plus a randomized run, all
// checked against a queue-based model of outstanding tags.
module tb_spec_tag_tracker;

  localparam int DEPTH = 8;
  localparam int TAG_W = 4;
  localparam int NTAGS = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             alloc_req = 1'b0;
  logic             res_valid = 1'b0;
  logic [TAG_W-1:0] res_tag = '0;
  logic             res_mispred = 1'b0;
  logic             alloc_ready, res_ready, l_valid, retire_valid, res_err;
  logic [TAG_W-1:0] alloc_tag, l_status, retire_tag;
  logic [3:0]       count;

  always #5 clk = ~clk;

  spec_tag_tracker #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_req    (alloc_req),
    .alloc_ready  (alloc_ready),
    .alloc_tag    (alloc_tag),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_tag      (res_tag),
    .res_mispred  (res_mispred),
    .l_valid      (l_valid),
    .l_status     (l_status),
    .retire_valid (retire_valid),
    .retire_tag   (retire_tag),
    .res_err      (res_err),
    .count        (count)
  );

  // Model: oldest-first list of outstanding tags with their resolved flags.
  typedef struct {
    int tag;
    bit resolved;
  } m_entry_t;

  m_entry_t mq[$];
  int       m_next  = 0;
  bit       m_flush = 0;

  int errors = 0;
  int checks = 0;

  bit   e_ar, e_rr, e_lv, e_rv, e_err;
  int   e_at, e_ls, e_rt, e_cnt;
  logic s_ar, s_rr;
  logic [TAG_W-1:0] s_at;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; alloc_req = 0; res_valid = 0; res_tag = '0; res_mispred = 0;
    @(posedge clk); @(posedge clk); #1;
    mq.delete(); m_next = 0; m_flush = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock of stimulus; the model advances alongside, leaving expected and
  // sampled values for the calling test to compare.
  task automatic step(input bit a, input bit rv, input int rt, input bit rm);
    int pos;
    bit fire, ok, mis, cor, ret, afire;
    @(negedge clk);
    alloc_req = a; res_valid = rv; res_tag = TAG_W'(rt); res_mispred = rm;
    #1;
    s_ar = alloc_ready; s_rr = res_ready; s_at = alloc_tag;
    e_rr = !m_flush;
    e_ar = (mq.size() < DEPTH) && !m_flush && !(rv && e_rr && rm);
    e_at = m_next;
    pos = -1;
    foreach (mq[i]) if (mq[i].tag == rt) pos = i;
    fire  = rv && e_rr;
    ok    = fire && (pos >= 0) && !mq[pos].resolved;
    mis   = ok && rm;
    cor   = ok && !rm;
    ret   = (mq.size() > 0) && mq[0].resolved && !(mis && pos == 0);
    afire = a && e_ar;
    e_lv  = mis;
    e_ls  = rt;
    e_rv  = ret;
    e_rt  = ret ? mq[0].tag : 0;
    e_err = fire && !ok;
    if (cor) mq[pos].resolved = 1;
    if (mis) begin
      while (mq.size() > pos) void'(mq.pop_back());
      m_next = rt;
    end
    if (ret) void'(mq.pop_front());
    if (afire) begin
      mq.push_back('{tag: m_next, resolved: 1'b0});
      m_next = (m_next + 1) % NTAGS;
    end
    m_flush = mis;
    e_cnt = mq.size();
    @(posedge clk); #1;
    $display("t=%0t alloc=%b rdy=%b tag=%0d | res=%b tag=%0d mis=%b | lv=%b ls=%0d rv=%b rt=%0d err=%b cnt=%0d",
             $time, a, s_ar, s_at, rv, rt, rm, l_valid, l_status, retire_valid, retire_tag, res_err, count);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; alloc_req = 1; res_valid = 1; res_tag = 4'd3; res_mispred = 1;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL reset_alloc_ready got=%b exp=0", alloc_ready); end
    checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL reset_res_ready got=%b exp=0", res_ready); end
    checks++; if ({l_valid, retire_valid, res_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses got=%b exp=000", {l_valid, retire_valid, res_err}); end
    checks++; if (count !== 4'd0 || alloc_tag !== 4'd0) begin errors++; $display("FAIL reset_count_tag got=%0d/%0d exp=0/0", count, alloc_tag); end
    do_reset();
    #1;
    checks++; if (alloc_ready !== 1'b1 || res_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b%b exp=11", alloc_ready, res_ready); end
  endtask

  task automatic test_alloc();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      checks++; if (s_at !== TAG_W'(i) || s_ar !== 1'b1) begin errors++; $display("FAIL alloc_tag%0d got=%0d/%b exp=%0d/1", i, s_at, s_ar, i); end
    end
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL alloc_count got=%0d exp=3", count); end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL alloc_ready_after got=%b exp=1", alloc_ready); end
  endtask

  task automatic test_inorder_retire();
    step(0, 1, 1, 0);
    checks++; if (retire_valid !== 1'b0 || res_err !== 1'b0 || count !== 4'd3) begin errors++; $display("FAIL ret_res1 got=rv%b err%b cnt%0d exp=rv0 err0 cnt3", retire_valid, res_err, count); end
    step(0, 1, 0, 0);
    checks++; if (retire_valid !== 1'b0 || count !== 4'd3) begin errors++; $display("FAIL ret_res0 got=rv%b cnt%0d exp=rv0 cnt3", retire_valid, count); end
    step(0, 0, 0, 0);
    checks++; if (retire_valid !== 1'b1 || retire_tag !== 4'd0 || count !== 4'd2) begin errors++; $display("FAIL ret_first got=rv%b tag%0d cnt%0d exp=rv1 tag0 cnt2", retire_valid, retire_tag, count); end
    step(0, 0, 0, 0);
    checks++; if (retire_valid !== 1'b1 || retire_tag !== 4'd1 || count !== 4'd1) begin errors++; $display("FAIL ret_second got=rv%b tag%0d cnt%0d exp=rv1 tag1 cnt1", retire_valid, retire_tag, count); end
    step(0, 0, 0, 0);
    checks++; if (retire_valid !== 1'b0 || count !== 4'd1) begin errors++; $display("FAIL ret_idle got=rv%b cnt%0d exp=rv0 cnt1", retire_valid, count); end
  endtask

  task automatic test_mispredict();
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
    step(0, 1, 2, 1);
    checks++; if (l_valid !== 1'b1 || l_status !== 4'd2) begin errors++; $display("FAIL mis_pulse got=lv%b ls%0d exp=lv1 ls2", l_valid, l_status); end
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL mis_count got=%0d exp=2", count); end
    step(1, 0, 0, 0);
    checks++; if (s_ar !== 1'b0 || s_rr !== 1'b0) begin errors++; $display("FAIL mis_flush_block got=ar%b rr%b exp=ar0 rr0", s_ar, s_rr); end
    checks++; if (l_valid !== 1'b0 || count !== 4'd2) begin errors++; $display("FAIL mis_one_cycle got=lv%b cnt%0d exp=lv0 cnt2", l_valid, count); end
    step(1, 0, 0, 0);
    checks++; if (s_ar !== 1'b1 || s_at !== 4'd2 || count !== 4'd3) begin errors++; $display("FAIL mis_reuse got=ar%b tag%0d cnt%0d exp=ar1 tag2 cnt3", s_ar, s_at, count); end
  endtask

  task automatic test_full_wrap();
    int n_alloc;
    int pick;
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    checks++; if (s_ar !== 1'b0 || count !== 4'd8) begin errors++; $display("FAIL full_block got=ar%b cnt%0d exp=ar0 cnt8", s_ar, count); end
    step(1, 1, 0, 0);
    checks++; if (s_ar !== 1'b0) begin errors++; $display("FAIL full_res_block got=%b exp=0", s_ar); end
    step(1, 0, 0, 0);
    checks++; if (s_ar !== 1'b0) begin errors++; $display("FAIL full_no_bypass got=%b exp=0", s_ar); end
    checks++; if (retire_valid !== 1'b1 || retire_tag !== 4'd0 || count !== 4'd7) begin errors++; $display("FAIL full_retire got=rv%b tag%0d cnt%0d exp=rv1 tag0 cnt7", retire_valid, retire_tag, count); end
    step(1, 0, 0, 0);
    checks++; if (s_ar !== 1'b1 || s_at !== 4'd8) begin errors++; $display("FAIL full_ready_again got=ar%b tag%0d exp=ar1 tag8", s_ar, s_at); end
    n_alloc = 9;
    for (int k = 0; k < 60 && n_alloc < 20; k++) begin
      pick = 0;
      foreach (mq[i]) if (!mq[i].resolved) begin pick = mq[i].tag; break; end
      step(1, 1, pick, 0);
      if (s_ar === 1'b1) n_alloc++;
      checks++; if (s_ar !== e_ar || s_at !== TAG_W'(e_at)) begin errors++; $display("FAIL wrap_alloc got=ar%b tag%0d exp=ar%b tag%0d", s_ar, s_at, e_ar, e_at); end
      checks++; if (count !== 4'(e_cnt) || retire_valid !== e_rv || (e_rv && retire_tag !== TAG_W'(e_rt))) begin errors++; $display("FAIL wrap_state got=cnt%0d rv%b rt%0d exp=cnt%0d rv%b rt%0d", count, retire_valid, retire_tag, e_cnt, e_rv, e_rt); end
    end
    checks++; if (n_alloc != 20 || alloc_tag !== 4'd4) begin errors++; $display("FAIL wrap_final got=allocs%0d tag%0d exp=allocs20 tag4", n_alloc, alloc_tag); end
  endtask

  task automatic test_errors();
    do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 9, 0);
    checks++; if (res_err !== 1'b1 || count !== 4'd2 || retire_valid !== 1'b0) begin errors++; $display("FAIL err_unalloc got=err%b cnt%0d rv%b exp=err1 cnt2 rv0", res_err, count, retire_valid); end
    step(0, 1, 1, 0);
    checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL err_first_ok got=%b exp=0", res_err); end
    step(0, 1, 1, 0);
    checks++; if (res_err !== 1'b1 || count !== 4'd2 || retire_valid !== 1'b0) begin errors++; $display("FAIL err_twice got=err%b cnt%0d rv%b exp=err1 cnt2 rv0", res_err, count, retire_valid); end
    step(0, 0, 0, 0);
    checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL err_one_cycle got=%b exp=0", res_err); end
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    checks++; if (res_err !== e_err || count !== 4'(e_cnt) || retire_valid !== e_rv) begin errors++; $display("FAIL err_head_twice got=err%b cnt%0d rv%b exp=err%b cnt%0d rv%b", res_err, count, retire_valid, e_err, e_cnt, e_rv); end
  endtask

  task automatic test_mispred_head_alloc();
    do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 1);
    checks++; if (s_ar !== 1'b0) begin errors++; $display("FAIL mhead_alloc got=%b exp=0", s_ar); end
    checks++; if (l_valid !== 1'b1 || l_status !== 4'd0 || retire_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL mhead_state got=lv%b ls%0d rv%b cnt%0d exp=lv1 ls0 rv0 cnt0", l_valid, l_status, retire_valid, count); end
    step(1, 0, 0, 0);
    checks++; if (s_ar !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL mhead_flush got=ar%b cnt%0d exp=ar0 cnt0", s_ar, count); end
    step(1, 0, 0, 0);
    checks++; if (s_ar !== 1'b1 || s_at !== 4'd0) begin errors++; $display("FAIL mhead_resume got=ar%b tag%0d exp=ar1 tag0", s_ar, s_at); end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(0, 1, 1, 1);
    @(negedge clk);
    rst_n = 1'b0; alloc_req = 0; res_valid = 0; res_mispred = 0;
    @(posedge clk); #1;
    mq.delete(); m_next = 0; m_flush = 0;
    checks++; if (l_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL rflush_state got=lv%b cnt%0d exp=lv0 cnt0", l_valid, count); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (alloc_ready !== 1'b1 || res_ready !== 1'b1 || alloc_tag !== 4'd0) begin errors++; $display("FAIL rflush_run got=ar%b rr%b tag%0d exp=ar1 rr1 tag0", alloc_ready, res_ready, alloc_tag); end
  endtask

  task automatic test_random();
    bit a, rv, rm;
    int rt;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      a  = ($urandom_range(0, 3) != 0);
      rv = $urandom_range(0, 1) == 1;
      rm = ($urandom_range(0, 9) == 0);
      if (mq.size() > 0 && $urandom_range(0, 7) != 0) rt = mq[$urandom_range(0, mq.size() - 1)].tag;
      else rt = $urandom_range(0, NTAGS - 1);
      step(a, rv, rt, rm);
      checks++; if (s_ar !== e_ar || s_rr !== e_rr || s_at !== TAG_W'(e_at)) begin errors++; $display("FAIL rand_comb c=%0d got=ar%b rr%b tag%0d exp=ar%b rr%b tag%0d", c, s_ar, s_rr, s_at, e_ar, e_rr, e_at); end
      checks++; if (l_valid !== e_lv || (e_lv && l_status !== TAG_W'(e_ls))) begin errors++; $display("FAIL rand_l c=%0d got=lv%b ls%0d exp=lv%b ls%0d", c, l_valid, l_status, e_lv, e_ls); end
      checks++; if (retire_valid !== e_rv || (e_rv && retire_tag !== TAG_W'(e_rt))) begin errors++; $display("FAIL rand_retire c=%0d got=rv%b rt%0d exp=rv%b rt%0d", c, retire_valid, retire_tag, e_rv, e_rt); end
      checks++; if (res_err !== e_err || count !== 4'(e_cnt)) begin errors++; $display("FAIL rand_err_cnt c=%0d got=err%b cnt%0d exp=err%b cnt%0d", c, res_err, count, e_err, e_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_inorder_retire();
    test_mispredict();
    test_full_wrap();
    test_errors();
    test_mispred_head_alloc();
    test_reset_mid_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
